// File: rtl/riscv_core_rf_sb.sv
// Parametrised multi-read-port register file with write-through bypass and a
// per-register busy scoreboard that decode uses to detect RAW hazards.
module riscv_core_rf_sb #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREG   = 32,
  parameter int unsigned NRD    = 2,
  parameter bit          BYPASS = 1'b1,
  localparam int unsigned AW    = $clog2(NREG)
) (
  input  logic              i_rf_clk,
  input  logic              i_rf_rst_n,
  input  logic [NRD*AW-1:0]   i_rf_ra,
  output logic [NRD*XLEN-1:0] o_rf_rd,
  output logic [NRD-1:0]      o_rf_busy,
  input  logic              i_rf_we,
  input  logic [AW-1:0]     i_rf_wa,
  input  logic [XLEN-1:0]   i_rf_wd,
  input  logic              i_rf_rsv_en,
  input  logic [AW-1:0]     i_rf_rsv_a,
  input  logic              i_rf_flush,
  output logic [AW:0]       o_rf_busy_cnt
);

  logic [XLEN-1:0] rf_q [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic            wr_ok;
  logic            rsv_ok;

  assign wr_ok  = i_rf_we && (i_rf_wa != '0);
  assign rsv_ok = i_rf_rsv_en && (i_rf_rsv_a != '0);

  always_ff @(posedge i_rf_clk or negedge i_rf_rst_n) begin
    if (!i_rf_rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
    end else if (wr_ok) begin
      rf_q[i_rf_wa] <= i_rf_wd;
    end
  end

  // Reserve is applied after the writeback clear so a new producer wins.
  always_comb begin
    busy_d = busy_q;
    if (i_rf_flush) begin
      busy_d = '0;
    end else begin
      if (wr_ok) begin
        busy_d[i_rf_wa] = 1'b0;
      end
      if (rsv_ok) begin
        busy_d[i_rf_rsv_a] = 1'b1;
      end
    end
  end

  always_ff @(posedge i_rf_clk or negedge i_rf_rst_n) begin
    if (!i_rf_rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  always_comb begin
    o_rf_busy_cnt = '0;
    for (int i = 1; i < NREG; i++) begin
      o_rf_busy_cnt = o_rf_busy_cnt + (AW+1)'(busy_q[i]);
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] ra;
    logic          is_zero;
    logic          hit;

    assign ra      = i_rf_ra[k*AW +: AW];
    assign is_zero = (ra == '0);
    assign hit     = BYPASS && i_rf_we && (i_rf_wa == ra);

    assign o_rf_rd[k*XLEN +: XLEN] = is_zero ? '0 : (hit ? i_rf_wd : rf_q[ra]);
    // Forwarded data satisfies the consumer, so the hazard is masked.
    assign o_rf_busy[k] = !is_zero && !hit && busy_q[ra];
  end

endmodule

// File: doc/riscv_core_rf_sb.md
Name: riscv_core_rf_sb

Overview:
Parametrised successor to the core's 2R/1W register file. It adds a configurable number of read ports, a posedge write with optional same-cycle write-through bypass, and an async-reset-cleared register array. It also carries a per-register scoreboard of busy bits: the decode stage reserves destinations at issue and writeback releases them, so decode can detect RAW hazards directly from the read ports.

Parameters:
XLEN, 32, data width in bits.
NREG, 32, number of architectural registers; power of two, >= 2.
AW, $clog2(NREG), address width; derived localparam, not overridable.
NRD, 2, number of read ports, 1..4.
BYPASS, 1, 1 = write data forwarded combinationally to matching read ports in the same cycle.

Ports:
i_rf_clk  input  1  clock; all state updates on posedge.
i_rf_rst_n  input  1  asynchronous active-low reset.
i_rf_ra  input  NRD*AW  read addresses; port k uses bits [k*AW +: AW].
o_rf_rd  output  NRD*XLEN  read data; port k uses bits [k*XLEN +: XLEN].
o_rf_busy  output  NRD  per-port scoreboard hit: the addressed register has a pending producer.
i_rf_we  input  1  write enable.
i_rf_wa  input  AW  write address.
i_rf_wd  input  XLEN  write data.
i_rf_rsv_en  input  1  reserve a destination, asserted at issue.
i_rf_rsv_a  input  AW  register to reserve.
i_rf_flush  input  1  clear all busy bits (pipeline flush).
o_rf_busy_cnt  output  AW+1  number of registers currently marked busy.

Behaviour:
- Reset (i_rf_rst_n low, asynchronous): every array entry = 0, every busy bit = 0. Outputs therefore read 0, o_rf_busy = 0, o_rf_busy_cnt = 0. Reset mid-operation drops all pending writes and reservations immediately.
- Register 0 is hardwired:
  - reads return 0;
  - writes to address 0 are ignored;
  - reservations of address 0 are ignored;
  - busy[0] is always 0.
- Write: at posedge, if i_rf_we and i_rf_wa != 0, then rf[i_rf_wa] <= i_rf_wd. New value is visible through the array from the next cycle.
- Read (combinational) for port k with address a = ra_k:
  - a == 0: data = 0.
  - BYPASS=1 and i_rf_we and i_rf_wa == a: data = i_rf_wd.
  - otherwise: data = rf[a].
  - BYPASS=0: array value only; the old value is returned in the write cycle.
- Scoreboard update, evaluated at posedge in this priority order:
  1. i_rf_flush: all busy bits <= 0. Any i_rf_rsv_en in the same cycle is ignored. A write in the same cycle still updates the array.
  2. Else, reserve and write to the same nonzero address in the same cycle: busy stays / becomes 1. The reserve wins because a new producer was issued.
  3. Else, write to a nonzero address: busy[wa] <= 0.
  4. Else, reserve of a nonzero address: busy[rsv_a] <= 1. Reserving an already-busy register leaves it at 1; WAW depth is not counted.
  5. A reserve and a write to different addresses in the same cycle both take effect.
- o_rf_busy[k] (combinational):
  - = busy[ra_k] when BYPASS=0.
  - When BYPASS=1, also forced to 0 if i_rf_we and i_rf_wa == ra_k, because the data is being forwarded this cycle.
  - Always 0 for address 0.
- o_rf_busy_cnt: population count of the busy vector; reflects registered state only. Range 0..NREG-1.
- Latency:
  - read: 0 cycles;
  - write to array-read: 1 cycle (0 with bypass);
  - reserve to busy visible: 1 cycle;
  - writeback to busy clear: 0 cycles with bypass, 1 cycle without.
- No X propagation: out-of-range addresses cannot occur since NREG = 2^AW.

Test Plan:
- Reset: write rf[5]=0xDEAD_BEEF, reserve r7, pulse i_rf_rst_n low mid-cycle -> immediately rd(r5)=0, busy(r7)=0, busy_cnt=0.
- x0: we=1, wa=0, wd=0xFFFF_FFFF and rsv_en=1, rsv_a=0 -> rd(r0)=0 on all ports; busy_cnt stays 0.
- Bypass: BYPASS=1, we=1, wa=3, wd=0x1234_5678, ra0=ra1=3 -> both ports return 0x1234_5678 in the same cycle. Repeat with BYPASS=0 -> old value this cycle, new value next cycle.
- Scoreboard: reserve r10 -> next cycle busy=1 on the port reading r10, busy_cnt=1. Write r10=0xA5A5_A5A5 -> same cycle busy=0 with data forwarded; next cycle busy_cnt=0.
- Simultaneous events:
  - reserve r4 plus write r4 in one cycle -> busy(r4)=1 afterwards;
  - reserve r6 plus write r9 (r9 previously busy) -> busy(r6)=1, busy(r9)=0.
- Flush: reserve r1, r2, r3 on consecutive cycles (busy_cnt=3). Then flush plus rsv r8 plus write r2=0x77 -> busy_cnt=0, r8 not busy, rd(r2)=0x77. NRD=4 build: each port independently addresses r1..r4 with correct data and busy flags.
